// File: rtl/f_spsram_param_pkg.sv
// f_spsram_param_pkg: shared state encoding and parameter helpers for the parametrised SRAM
package f_spsram_param_pkg;
  typedef enum logic [1:0] {IDLE, INIT, READY} state_e;
  function automatic int lanes(int data_width, int lane_width);
    return data_width / lane_width;
  endfunction
  function automatic bit params_ok(int data_width, int lane_width, int read_latency);
    return lane_width > 0 && data_width % lane_width == 0 && (read_latency == 1 || read_latency == 2);
  endfunction
endpackage

// File: rtl/f_spsram_param_if.sv
// f_spsram_param_if: user port of the SRAM (active-low enables, address, data, busy)
interface f_spsram_param_if
  import f_spsram_param_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int LANE_WIDTH = 8,
  parameter int DEPTH = 32768
);
  localparam int LANES = lanes(DATA_WIDTH, LANE_WIDTH);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  logic cen;
  logic [LANES-1:0] wen;
  logic [ADDR_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] d;
  logic [DATA_WIDTH-1:0] q;
  logic busy;
  modport master(output cen, wen, a, d, input q, busy);
  modport slave(input cen, wen, a, d, output q, busy);
endinterface

// File: rtl/f_spsram_param_lane.sv
// f_spsram_param_lane: one write-mask lane of storage with synchronous write-first read
module f_spsram_param_lane #(
  parameter int LANE_WIDTH = 8,
  parameter int DEPTH = 32768,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [LANE_WIDTH-1:0] din_i,
  input  logic                  we_i,
  input  logic                  re_i,
  output logic [LANE_WIDTH-1:0] dout_o
);
  logic [LANE_WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= din_i;
    if (re_i) dout_o <= we_i ? din_i : mem_q[addr_i];
  end
endmodule

// File: rtl/f_spsram_param.sv
// f_spsram_param: single-port SRAM with per-lane active-low write masks, post-reset init
// engine and optional second output register
module f_spsram_param
  import f_spsram_param_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int LANE_WIDTH = 8,
  parameter int DEPTH = 32768,
  parameter int READ_LATENCY = 1,
  parameter int INIT_EN = 1,
  parameter logic [LANE_WIDTH-1:0] INIT_VALUE = '0
) (
  input logic clk_i,
  input logic rst_i,
  f_spsram_param_if.slave bus
);
  localparam int LANES = lanes(DATA_WIDTH, LANE_WIDTH);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  if (!params_ok(DATA_WIDTH, LANE_WIDTH, READ_LATENCY)) begin : g_bad_params
    $error("f_spsram_param: DATA_WIDTH must be a multiple of LANE_WIDTH and READ_LATENCY 1 or 2");
  end
  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d, addr_q, addr;
  logic vld_q, ld1_q, busy, init_wr, acc, hit, re;
  logic [LANES-1:0] we;
  logic [DATA_WIDTH-1:0] dout, q1, q2_q;
  assign busy = (INIT_EN != 0) && (state_q != READY);
  assign init_wr = busy && !rst_i;
  assign acc = !rst_i && !busy && !bus.cen;
  assign hit = acc && ({1'b0, bus.a} < DEPTH_W);
  assign re = hit;
  assign addr = init_wr ? cnt_q : bus.a;
  always_comb begin
    state_d = init_wr ? (cnt_q == LAST ? READY : INIT) : (INIT_EN != 0 ? state_q : READY);
    cnt_d = init_wr ? (cnt_q == LAST ? '0 : cnt_q + 1'b1) : cnt_q;
    we = init_wr ? '1 : (hit ? ~bus.wen : '0);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      vld_q <= 1'b0;
      ld1_q <= 1'b0;
      q2_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (acc) addr_q <= bus.a;
      vld_q <= vld_q | acc;
      ld1_q <= acc;
      if (ld1_q) q2_q <= q1;
    end
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    f_spsram_param_lane #(
      .LANE_WIDTH(LANE_WIDTH),
      .DEPTH(DEPTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_lane (
      .clk_i(clk_i),
      .addr_i(addr),
      .din_i(init_wr ? INIT_VALUE : bus.d[i*LANE_WIDTH +: LANE_WIDTH]),
      .we_i(we[i]),
      .re_i(re),
      .dout_o(dout[i*LANE_WIDTH +: LANE_WIDTH])
    );
  end
  // an out-of-range access leaves the lanes untouched, so its result is forced to zero here
  assign q1 = (vld_q && ({1'b0, addr_q} < DEPTH_W)) ? dout : '0;
  assign bus.q = READ_LATENCY == 2 ? q2_q : q1;
  assign bus.busy = busy;
  always_ff @(posedge clk_i) begin
    if (!rst_i && !busy) assert (!$isunknown(bus.cen));
  end
endmodule
